// File: rtl/bram_snapshot_writer_pkg.sv
// bram_snapshot_writer_pkg: shared state encoding for the snapshot capture blocks
package bram_snapshot_writer_pkg;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;
endpackage

// File: rtl/bram_snapshot_writer_if.sv
// bram_snapshot_writer_if: sample stream in, BRAM write port out
interface bram_snapshot_writer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [DATA_WIDTH-1:0] din;
  logic                  din_valid;
  logic [ADDR_WIDTH-1:0] bram_addr;
  logic [DATA_WIDTH-1:0] bram_din;
  logic                  bram_we;
  modport master (input din, din_valid, output bram_addr, bram_din, bram_we);
  modport slave (output din, din_valid, input bram_addr, bram_din, bram_we);
endinterface

// File: rtl/bram_snapshot_writer_trigger_edge_detect.sv
// trigger_edge_detect: rising edge of trig_in or level soft_trig gives trig_hit
module trigger_edge_detect (
  input  logic fpga_clk,
  input  logic rst,
  input  logic trig_in,
  input  logic soft_trig,
  output logic trig_hit
);
  logic trig_d;
  always_ff @(posedge fpga_clk or posedge rst)
    if (rst) trig_d <= 1'b0;
    else trig_d <= trig_in;
  assign trig_hit = (trig_in & ~trig_d) | soft_trig;
endmodule

// File: rtl/bram_snapshot_writer.sv
// bram_snapshot_writer: armed single-shot capture of decimated samples into BRAM from address 0
module bram_snapshot_writer
  import bram_snapshot_writer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int DECIM_WIDTH = 8
) (
  input  logic                   fpga_clk,
  input  logic                   rst,
  bram_snapshot_writer_if.master bus,
  input  logic                   arm,
  input  logic                   abort,
  input  logic                   soft_trig,
  input  logic                   trig_in,
  input  logic [ADDR_WIDTH-1:0]  capture_len,
  input  logic [DECIM_WIDTH-1:0] decim,
  output logic                   armed,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_WIDTH:0]    wr_count
);
  state_t                 state;
  logic [ADDR_WIDTH:0]    len_q;
  logic [DECIM_WIDTH-1:0] decim_q, dcnt, dcnt_cur, dcnt_nxt;
  logic [ADDR_WIDTH:0]    wr_nxt;
  logic                   trig_hit, start, active, qual, last;
  trigger_edge_detect u_trig (
    .fpga_clk (fpga_clk),
    .rst      (rst),
    .trig_in  (trig_in),
    .soft_trig(soft_trig),
    .trig_hit (trig_hit)
  );
  // the trigger cycle itself counts as decimation phase 0
  always_comb begin
    start    = (state == ARMED) && trig_hit;
    active   = (state == CAPTURE) || start;
    dcnt_cur = start ? '0 : dcnt;
    dcnt_nxt = (dcnt_cur == decim_q) ? '0 : dcnt_cur + 1'b1;
    qual     = active && bus.din_valid && (dcnt_cur == '0);
    wr_nxt   = wr_count + 1'b1;
    last     = wr_nxt == len_q;
  end
  always_ff @(posedge fpga_clk or posedge rst)
    if (rst) begin
      state         <= IDLE;
      len_q         <= '0;
      decim_q       <= '0;
      dcnt          <= '0;
      wr_count      <= '0;
      bus.bram_we   <= 1'b0;
      bus.bram_addr <= '0;
      bus.bram_din  <= '0;
    end else begin
      bus.bram_we <= 1'b0;
      if (abort) state <= IDLE;
      else if (arm && (state == IDLE || state == DONE)) begin
        state    <= ARMED;
        len_q    <= {~|capture_len, capture_len};
        decim_q  <= decim;
        dcnt     <= '0;
        wr_count <= '0;
      end else if (active) begin
        if (bus.din_valid) dcnt <= dcnt_nxt;
        state <= (qual && last) ? DONE : CAPTURE;
        if (qual) begin
          bus.bram_we   <= 1'b1;
          bus.bram_din  <= DATA_WIDTH'(bus.din);
          bus.bram_addr <= ADDR_WIDTH'(wr_count);
          wr_count      <= wr_nxt;
        end
      end
    end
  assign armed = state == ARMED;
  assign busy  = (state == ARMED) || (state == CAPTURE);
  assign done  = state == DONE;
endmodule

// File: doc/bram_snapshot_writer.md
Name: bram_snapshot_writer

Overview:
- Single-shot capture engine on the FPGA side of the dual-port AXI-lite BRAM.
- Once armed, it waits for a trigger, then writes a programmable number of streaming samples into consecutive BRAM addresses starting at 0, then flags done.
- Its bram_din/bram_addr/bram_we outputs drive the BRAM's fpga-side write port directly; the PS reads the snapshot over AXI-lite.

Parameters:
- DATA_WIDTH, 32, sample and BRAM word width.
- ADDR_WIDTH, 10, BRAM address width; depth = 2**ADDR_WIDTH.
- DECIM_WIDTH, 8, width of the decimation factor input.

Ports:
- fpga_clk  in  1  sole clock.
- rst  in  1  asynchronous reset, active-high.
- din  in  DATA_WIDTH  sample stream.
- din_valid  in  1  din qualifier.
- arm  in  1  pulse: latch config, enter ARMED.
- abort  in  1  pulse: return to IDLE immediately.
- soft_trig  in  1  level-sensitive software trigger, ARMED only.
- trig_in  in  1  external trigger, rising-edge detected; already synchronous to fpga_clk.
- capture_len  in  ADDR_WIDTH  samples to write; 0 means 2**ADDR_WIDTH. Latched on arm.
- decim  in  DECIM_WIDTH  store every (decim+1)-th valid sample. Latched on arm.
- bram_addr  out  ADDR_WIDTH  write address.
- bram_din  out  DATA_WIDTH  write data.
- bram_we  out  1  write enable.
- armed  out  1  high in ARMED.
- busy  out  1  high in ARMED or CAPTURE.
- done  out  1  high in DONE.
- wr_count  out  ADDR_WIDTH+1  samples written in the current or last capture.

Behaviour:
- Reset: state IDLE; all outputs 0; trigger history register 0; latched config 0.
- Edge detect: trig_edge = trig_in & ~trig_d. trig_d is registered every cycle in all states.
- Trigger event (trig_hit) = trig_edge | soft_trig.
- States: IDLE, ARMED, CAPTURE, DONE.
  - IDLE/DONE: arm -> ARMED. On that transition, latch capture_len and decim, and clear wr_count and the decimation counter. done drops the cycle after arm.
  - ARMED: trig_hit -> CAPTURE. A trigger in the same cycle as arm is ignored; arm takes effect first.
  - CAPTURE: a qualifying sample is written. When the written count reaches the latched length -> DONE.
  - abort in any state -> IDLE next cycle. wr_count keeps its value; bram_we is 0 from the next cycle onward.
  - arm while ARMED or CAPTURE is ignored. abort wins over arm in the same cycle.
- Sample qualification:
  - A decimation counter runs on din_valid, starting at 0 on the trigger cycle.
  - A sample qualifies when din_valid=1 and the counter is 0. The counter wraps after the latched decim value.
- The trigger-cycle sample is captured:
  - If din_valid is high in the cycle trig_hit is accepted in ARMED, that sample is written to address 0.
  - Otherwise, the first qualifying sample after the trigger goes to address 0.
- Write timing:
  - Outputs are registered, latency 1: a qualifying sample at cycle N gives bram_we=1 at N+1, with bram_din=that sample and bram_addr=wr_count(N) truncated to ADDR_WIDTH.
  - bram_we is a one-cycle pulse per sample and is 0 at all other times.
- wr_count increments in the cycle the write is registered.
- Transition to DONE happens in the same cycle the last write is registered; done=1 coincides with the final bram_we.
- Full-depth capture (capture_len=0, length 2**ADDR_WIDTH):
  - The address runs 0..2**ADDR_WIDTH-1 with no wrap and no second write to address 0.
  - wr_count ends at 2**ADDR_WIDTH, which is why it is ADDR_WIDTH+1 bits wide.
- din_valid gaps in CAPTURE stall progress, with no writes and no timeout.
- The decimation counter advances only on din_valid.
- Reset mid-capture: immediate IDLE; bram_we forced 0 asynchronously.

Decomposition:
- Shared package: state encoding constants (IDLE=0, ARMED=1, CAPTURE=2, DONE=3).
- Sub-module: trigger_edge_detect (trig_in, soft_trig -> trig_hit). It is small and is reused by later capture blocks.
- All else lives in one module.

Test Plan:
- ADDR_WIDTH=4, capture_len=5, decim=0, continuous din=100+n:
  - Stimulus: arm, then trig_in rising at sample 100+k.
  - Required: addresses 0..4 hold 100+k..104+k, exactly 5 bram_we pulses, done=1 with the last write, wr_count=5.
- capture_len=0, ADDR_WIDTH=4:
  - Required: 16 writes to addresses 0..15, wr_count=16, no write to address 0 after the first.
- decim=2, capture_len=3, din counting 0.., trigger at din=10:
  - Required: writes 10, 13, 16 to addresses 0, 1, 2.
- din_valid toggling 1/0, capture_len=4:
  - Required: exactly 4 writes, each one cycle after a valid sample, and no bram_we during gaps.
- abort after 2 writes (capture_len=8):
  - Required: state IDLE, bram_we=0 from the next cycle, wr_count=2, done=0.
  - Then re-arm + soft_trig: capture restarts at address 0.
- Trigger edge cases:
  - trig_in high at arm time (no new edge): stays ARMED.
  - trig_in held high then low-high: triggers once.
  - arm+trig_in rise in the same cycle: trigger ignored.
  - arm during CAPTURE: ignored.
